// File: rtl/anabellek_hakem_if.sv
// Bus bundle between the two caches, the arbiter and the anabellek controller.
// slave is the arbiter's view; master is the surrounding caches/controller view.
interface anabellek_hakem_if;
  logic         b_istek_i;
  logic [31:0]  b_adres_i;
  logic         b_musait_o;
  logic         b_hazir_o;
  logic [127:0] b_obek_o;

  logic         v_istek_i;
  logic [31:0]  v_adres_i;
  logic         v_yaz_i;
  logic [127:0] v_obek_i;
  logic         v_musait_o;
  logic         v_hazir_o;
  logic [127:0] v_obek_o;

  logic         anabellek_musait_i;
  logic         anabellek_hazir_i;
  logic [127:0] anabellek_obek_i;
  logic         anabellek_istek_o;
  logic [31:0]  anabellek_adres_o;
  logic         anabellek_oku_o;
  logic         anabellek_yaz_o;
  logic [127:0] anabellek_obek_o;

  logic         hata_o;

  modport slave (
    input  b_istek_i, b_adres_i, v_istek_i, v_adres_i, v_yaz_i, v_obek_i,
           anabellek_musait_i, anabellek_hazir_i, anabellek_obek_i,
    output b_musait_o, b_hazir_o, b_obek_o, v_musait_o, v_hazir_o, v_obek_o,
           anabellek_istek_o, anabellek_adres_o, anabellek_oku_o, anabellek_yaz_o,
           anabellek_obek_o, hata_o
  );

  modport master (
    output b_istek_i, b_adres_i, v_istek_i, v_adres_i, v_yaz_i, v_obek_i,
           anabellek_musait_i, anabellek_hazir_i, anabellek_obek_i,
    input  b_musait_o, b_hazir_o, b_obek_o, v_musait_o, v_hazir_o, v_obek_o,
           anabellek_istek_o, anabellek_adres_o, anabellek_oku_o, anabellek_yaz_o,
           anabellek_obek_o, hata_o
  );
endinterface

// File: rtl/anabellek_hakem.sv
// Round-robin arbiter sharing the anabellek controller between the buyruk and veri caches,
// one latched transaction at a time, with a watchdog that aborts hung transfers.
module anabellek_hakem #(
  parameter int unsigned ZAMAN_ASIMI = 1024,
  parameter bit          VERI_ONCE   = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  anabellek_hakem_if.slave bus_io
);

  localparam int unsigned SayacW = $clog2(ZAMAN_ASIMI);
  localparam logic [SayacW-1:0] SayacSon = SayacW'(ZAMAN_ASIMI - 1);

  localparam logic [1:0] StBosta  = 2'd0;
  localparam logic [1:0] StBuyruk = 2'd1;
  localparam logic [1:0] StVeri   = 2'd2;

  logic [1:0]        durum_q, durum_d;
  logic              sira_q, sira_d;
  logic [31:0]       adres_q, adres_d;
  logic              yaz_q, yaz_d;
  logic [127:0]      obek_q, obek_d;
  logic [SayacW-1:0] sayac_q, sayac_d;

  logic aktif, bitti, zaman_doldu, musait, veri_kazandi;

  // Outputs are gated by rst_i so everything reads 0 while reset is held, even mid-transfer.
  always_comb begin
    aktif       = rst_i && (durum_q != StBosta);
    bitti       = aktif && bus_io.anabellek_hazir_i;
    zaman_doldu = aktif && !bus_io.anabellek_hazir_i && (sayac_q == SayacSon);
    musait      = rst_i && (durum_q == StBosta) && bus_io.anabellek_musait_i;
  end

  always_comb begin
    durum_d      = durum_q;
    sira_d       = sira_q;
    adres_d      = adres_q;
    yaz_d        = yaz_q;
    obek_d       = obek_q;
    sayac_d      = sayac_q;
    veri_kazandi = 1'b0;
    if (durum_q == StBosta) begin
      sayac_d = '0;
      if (musait && (bus_io.b_istek_i || bus_io.v_istek_i)) begin
        veri_kazandi = bus_io.v_istek_i && (!bus_io.b_istek_i || sira_q);
        // On a tie the loser is favoured next time.
        if (bus_io.b_istek_i && bus_io.v_istek_i) begin
          sira_d = !veri_kazandi;
        end
        if (veri_kazandi) begin
          durum_d = StVeri;
          adres_d = {bus_io.v_adres_i[31:4], 4'b0};
          yaz_d   = bus_io.v_yaz_i;
          obek_d  = bus_io.v_obek_i;
        end else begin
          durum_d = StBuyruk;
          adres_d = {bus_io.b_adres_i[31:4], 4'b0};
          yaz_d   = 1'b0;
          obek_d  = '0;
        end
      end
    end else if (bitti || zaman_doldu) begin
      durum_d = StBosta;
      sayac_d = '0;
    end else begin
      sayac_d = sayac_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q <= StBosta;
      sira_q  <= VERI_ONCE;
      adres_q <= '0;
      yaz_q   <= 1'b0;
      obek_q  <= '0;
      sayac_q <= '0;
    end else begin
      durum_q <= durum_d;
      sira_q  <= sira_d;
      adres_q <= adres_d;
      yaz_q   <= yaz_d;
      obek_q  <= obek_d;
      sayac_q <= sayac_d;
    end
  end

  always_comb begin
    bus_io.b_musait_o        = musait;
    bus_io.v_musait_o        = musait;
    bus_io.anabellek_istek_o = aktif && !bus_io.anabellek_hazir_i;
    bus_io.anabellek_adres_o = aktif ? adres_q : '0;
    bus_io.anabellek_oku_o   = aktif && !yaz_q;
    bus_io.anabellek_yaz_o   = aktif && yaz_q;
    bus_io.anabellek_obek_o  = aktif ? obek_q : '0;
    bus_io.b_hazir_o         = bitti && (durum_q == StBuyruk);
    bus_io.v_hazir_o         = bitti && (durum_q == StVeri);
    bus_io.b_obek_o          = bus_io.b_hazir_o ? bus_io.anabellek_obek_i : '0;
    bus_io.v_obek_o          = bus_io.v_hazir_o ? bus_io.anabellek_obek_i : '0;
    bus_io.hata_o            = zaman_doldu;
  end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Scoreboard bench for anabellek_hakem: expected transactions are queued as requests are raised
// and checked when the controller side sees them and when the owner's hazir pulse arrives.
module tb_anabellek_hakem;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  anabellek_hakem_if bus ();

  anabellek_hakem #(
    .ZAMAN_ASIMI(8),
    .VERI_ONCE  (1'b1)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus_io(bus)
  );

  typedef struct {
    bit           veri;
    logic [31:0]  adres;
    bit           yaz;
    logic [127:0] wobek;
    logic [127:0] robek;
  } txn_t;

  txn_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic req_b(input logic [31:0] adres);
    txn_t t;
    t = '{veri: 1'b0, adres: {adres[31:4], 4'h0}, yaz: 1'b0, wobek: '0, robek: rnd128()};
    exp_q.push_back(t);
    bus.b_istek_i = 1'b1;
    bus.b_adres_i = adres;
  endtask

  task automatic req_v(input logic [31:0] adres, input bit yaz, input logic [127:0] wd);
    txn_t t;
    t = '{veri: 1'b1, adres: {adres[31:4], 4'h0}, yaz: yaz, wobek: wd, robek: rnd128()};
    exp_q.push_back(t);
    bus.v_istek_i = 1'b1;
    bus.v_adres_i = adres;
    bus.v_yaz_i   = yaz;
    bus.v_obek_i  = wd;
  endtask

  task automatic drop(input bit veri);
    if (veri) bus.v_istek_i = 1'b0;
    else      bus.b_istek_i = 1'b0;
  endtask

  task automatic wait_istek(output int n);
    n = 0;
    @(negedge clk);
    while (bus.anabellek_istek_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("istek_seen", bus.anabellek_istek_o, 1'b1);
  endtask

  task automatic pop_exp(output txn_t t);
    check("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) t = exp_q.pop_front();
    else t = '{default: 0};
  endtask

  // lat = cycles the request is held before the controller answers.
  task automatic serve(input int lat, input bit dropit, output int n);
    txn_t t;
    wait_istek(n);
    pop_exp(t);
    check("mem_adres", bus.anabellek_adres_o, t.adres);
    check("mem_okuyaz", {bus.anabellek_oku_o, bus.anabellek_yaz_o}, {!t.yaz, t.yaz});
    check("mem_wobek", bus.anabellek_obek_o, t.yaz ? t.wobek : 128'h0);
    repeat (lat) begin
      @(posedge clk); #1;
      if (dropit) drop(t.veri);
      @(negedge clk);
      check("hold_ctl", {bus.anabellek_istek_o, bus.anabellek_oku_o, bus.anabellek_yaz_o,
                         bus.anabellek_adres_o, bus.hata_o}, {1'b1, !t.yaz, t.yaz, t.adres, 1'b0});
      check("hold_obek", bus.anabellek_obek_o, t.yaz ? t.wobek : 128'h0);
    end
    @(posedge clk); #1;
    bus.anabellek_hazir_i = 1'b1;
    bus.anabellek_obek_i  = t.robek;
    @(negedge clk);
    check("hazir_own", t.veri ? bus.v_hazir_o : bus.b_hazir_o, 1'b1);
    check("obek_own", t.veri ? bus.v_obek_o : bus.b_obek_o, t.robek);
    check("hazir_other", t.veri ? bus.b_hazir_o : bus.v_hazir_o, 1'b0);
    check("obek_other", t.veri ? bus.b_obek_o : bus.v_obek_o, 128'h0);
    check("istek_low", {bus.anabellek_istek_o, bus.hata_o}, 2'b00);
    @(posedge clk); #1;
    bus.anabellek_hazir_i = 1'b0;
    bus.anabellek_obek_i  = '0;
    drop(t.veri);
    @(negedge clk);
    check("pulse_end", {bus.b_hazir_o, bus.v_hazir_o}, 2'b00);
    check("bosta_musait", {bus.b_musait_o, bus.v_musait_o}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    txn_t t;
    logic h;
    rst_n = 1'b0;
    bus.b_istek_i = 1'b0; bus.b_adres_i = '0;
    bus.v_istek_i = 1'b0; bus.v_adres_i = '0; bus.v_yaz_i = 1'b0; bus.v_obek_i = '0;
    bus.anabellek_musait_i = 1'b1; bus.anabellek_hazir_i = 1'b0; bus.anabellek_obek_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_musait", {bus.b_musait_o, bus.v_musait_o}, 2'b00);
    check("rst_ctl", {bus.anabellek_istek_o, bus.anabellek_oku_o, bus.anabellek_yaz_o,
                      bus.hata_o, bus.b_hazir_o, bus.v_hazir_o}, 6'h0);
    check("rst_bus", {bus.anabellek_adres_o, bus.anabellek_obek_o}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_musait", {bus.b_musait_o, bus.v_musait_o}, 2'b11);

    // Single buyruk read, 5-cycle controller latency.
    @(posedge clk); #1 req_b(32'h0000_1234);
    serve(5, 1'b0, n);
    check("latency", n, 1);

    // First tie after reset goes to veri, then buyruk.
    @(posedge clk); #1 req_v(32'h0000_2008, 1'b0, '0); req_b(32'h0000_3004);
    serve(2, 1'b0, n);
    serve(3, 1'b0, n);
    check("regrant_gap", n, 0);

    // Next tie goes to buyruk.
    @(posedge clk); #1 req_b(32'h0000_4000); req_v(32'h0000_5000, 1'b0, '0);
    serve(1, 1'b0, n);
    serve(1, 1'b0, n);

    // Veri write-back.
    @(posedge clk); #1 req_v(32'h8000_0010, 1'b1, {16{8'hA5}});
    serve(4, 1'b0, n);

    // Owner drops istek mid-transfer; hazir still pulses.
    @(posedge clk); #1 req_b(32'h0000_6660);
    serve(4, 1'b1, n);

    // Stale hazir while idle.
    @(posedge clk); #1 bus.anabellek_hazir_i = 1'b1; bus.anabellek_obek_i = rnd128();
    @(negedge clk);
    check("stale_idle", {bus.b_hazir_o, bus.v_hazir_o, bus.anabellek_istek_o, bus.hata_o}, 4'h0);
    check("stale_obek", {bus.b_obek_o, bus.v_obek_o}, '0);
    @(posedge clk); #1 bus.anabellek_hazir_i = 1'b0; bus.anabellek_obek_i = '0;

    // Controller busy: requests wait.
    @(posedge clk); #1 bus.anabellek_musait_i = 1'b0; req_b(32'h0000_7770);
    repeat (3) begin
      @(negedge clk);
      check("wait_musait", {bus.b_musait_o, bus.v_musait_o, bus.anabellek_istek_o}, 3'b000);
    end
    @(posedge clk); #1 bus.anabellek_musait_i = 1'b1;
    serve(2, 1'b0, n);

    // Watchdog abort after 8 transfer cycles.
    @(posedge clk); #1 req_b(32'h0000_9990);
    wait_istek(n);
    pop_exp(t);
    check("wdog_adres", bus.anabellek_adres_o, t.adres);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      h = (i == 7);
      check("wdog_hata", {bus.hata_o, bus.b_hazir_o, bus.v_hazir_o}, {h, 2'b00});
    end
    @(posedge clk); #1 bus.b_istek_i = 1'b0;
    @(negedge clk);
    check("wdog_after", {bus.hata_o, bus.b_musait_o, bus.anabellek_istek_o}, 3'b010);

    // Reset in the middle of a veri write; held request is granted again afterwards.
    @(posedge clk); #1 req_v(32'h0000_AB3C, 1'b1, rnd128());
    wait_istek(n);
    pop_exp(t);
    check("rmid_adres", bus.anabellek_adres_o, t.adres);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rmid_ctl", {bus.anabellek_istek_o, bus.anabellek_oku_o, bus.anabellek_yaz_o,
                       bus.b_musait_o, bus.v_musait_o, bus.v_hazir_o, bus.hata_o}, 7'h0);
    check("rmid_bus", {bus.anabellek_adres_o, bus.anabellek_obek_o}, '0);
    @(posedge clk); #1 rst_n = 1'b1; bus.anabellek_hazir_i = 1'b1; bus.anabellek_obek_i = rnd128();
    @(negedge clk);
    check("rmid_stale", {bus.v_hazir_o, bus.b_hazir_o, bus.anabellek_istek_o, bus.hata_o}, 4'h0);
    @(posedge clk); #1 bus.anabellek_hazir_i = 1'b0; bus.anabellek_obek_i = '0;
    exp_q.push_back(t);
    serve(2, 1'b0, n);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
